rand_stream_mst: RTL

// - Synthesizable stream (ready/valid) source: the upstream stage of rand_stream_slv in stream benches.
// - Emits NumBeats beats per run with a counting or LFSR data pattern.
// - Inserts pseudo-random idle gaps of MinWaitCycles..MaxWaitCycles cycles between beats.
// - Fully deterministic from the seeds, so the sink side can predict the expected data.
//

---
 rtl/rand_stream_pkg.sv | 27 ++
 rtl/rand_stream_lfsr.sv | 30 +++
 rtl/rand_stream_mst.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rand_stream_pkg.sv
// rtl/rand_stream_pkg.sv - shared types and LFSR step function for the stream source
package rand_stream_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, VALID, DONE} mst_state_e;

    typedef enum logic {PAT_COUNT, PAT_LFSR} pattern_e;

    // Right-shifting Galois step; maximal-length taps for 16 and 32 bits, a simple
    // non-maximal polynomial for any other width.
    function automatic logic [31:0] lfsr_next(input int width, input logic [31:0] value);
        logic [31:0] taps;
        logic [31:0] mask;
        logic [31:0] nxt;
        case (width)
            16:      taps = 32'h0000_B400;
            32:      taps = 32'h8020_0003;
            default: taps = (32'(1) << (width - 1)) | 32'(1);
        endcase
        mask = (width >= 32) ? '1 : ((32'(1) << width) - 32'(1));
        nxt  = value >> 1;
        if (value[0]) begin
            nxt = nxt ^ taps;
        end
        return nxt & mask;
    endfunction

endpackage

// File: rtl/rand_stream_lfsr.sv
// rtl/rand_stream_lfsr.sv - seeded Galois LFSR with reload and step enable
module rand_stream_lfsr
    import rand_stream_pkg::*;
#(
    parameter int               Width = 16,
    parameter logic [Width-1:0] Seed  = Width'(1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    output logic [Width-1:0] q_o
);

    if (Width < 2 || Width > 32) begin : g_bad_width
        $fatal(1, "rand_stream_lfsr: Width must be 2..32");
    end
    if (Seed == '0) begin : g_bad_seed
        $fatal(1, "rand_stream_lfsr: Seed must be nonzero");
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || load_i) begin
            q_o <= Seed;
        end else if (en_i) begin
            q_o <= Width'(lfsr_next(Width, 32'(q_o)));
        end
    end

endmodule

// File: rtl/rand_stream_mst.sv
// rtl/rand_stream_mst.sv - deterministic ready/valid stream source with pseudo-random gaps
module rand_stream_mst
    import rand_stream_pkg::*;
#(
    parameter int          DataWidth     = 32,
    parameter int          NumBeats      = 16,
    parameter int          MinWaitCycles = 0,
    parameter int          MaxWaitCycles = 3,
    parameter pattern_e    Pattern       = PAT_COUNT,
    parameter logic [31:0] DataSeed      = 32'hACE1_2468,
    parameter logic [15:0] GapSeed       = 16'h1D0F
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    output logic [DataWidth-1:0]            data_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [$clog2(NumBeats+1)-1:0]   beats_sent_o
);

    localparam int BeatW    = $clog2(NumBeats + 1);
    localparam int CntW     = (MaxWaitCycles > 0) ? $clog2(MaxWaitCycles + 1) : 1;
    localparam int GapRange = MaxWaitCycles - MinWaitCycles + 1;
    localparam logic [DataWidth-1:0] DataSeedT = DataWidth'(DataSeed);

    if (NumBeats < 1) begin : g_bad_beats
        $fatal(1, "rand_stream_mst: NumBeats must be >= 1");
    end
    if (MinWaitCycles < 0 || MinWaitCycles > MaxWaitCycles) begin : g_bad_wait
        $fatal(1, "rand_stream_mst: need 0 <= MinWaitCycles <= MaxWaitCycles");
    end
    if (DataSeedT == '0 || GapSeed == '0) begin : g_bad_seed
        $fatal(1, "rand_stream_mst: seeds must be nonzero");
    end

    mst_state_e            state;
    mst_state_e            state_next;
    logic [CntW-1:0]       cnt;
    logic [CntW-1:0]       gap_val;
    logic                  gap_zero;
    logic [15:0]           gap_q;
    logic [DataWidth-1:0]  dlfsr_q;
    logic [DataWidth-1:0]  data_first;
    logic [DataWidth-1:0]  data_step;
    logic                  start_go;
    logic                  hs;
    logic                  last_beat;
    logic                  draw;

    assign start_go  = ((state == IDLE) || (state == DONE)) && start_i;
    assign hs        = (state == VALID) && ready_i;
    assign last_beat = beats_sent_o == BeatW'(NumBeats - 1);
    assign draw      = start_go || (hs && !last_beat);

    // With a single-value range the modulo is zero, so the gap collapses to the constant.
    assign gap_val  = CntW'(MinWaitCycles) + CntW'(32'(gap_q) % 32'(GapRange));
    assign gap_zero = gap_val == '0;

    assign data_first = (Pattern == PAT_LFSR) ? DataSeedT : '0;
    assign data_step  = (Pattern == PAT_LFSR) ? DataWidth'(lfsr_next(DataWidth, 32'(dlfsr_q)))
                                              : data_o + DataWidth'(1);

    rand_stream_lfsr #(
        .Width (16),
        .Seed  (GapSeed)
    ) u_gap_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (1'b0),
        .en_i   (draw && (GapRange > 1)),
        .q_o    (gap_q)
    );

    rand_stream_lfsr #(
        .Width (DataWidth),
        .Seed  (DataSeedT)
    ) u_data_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (start_go),
        .en_i   (hs),
        .q_o    (dlfsr_q)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start_i) begin
                    state_next = gap_zero ? VALID : WAIT;
                end
            end
            WAIT: begin
                if (cnt == CntW'(1)) begin
                    state_next = VALID;
                end
            end
            VALID: begin
                if (ready_i) begin
                    if (last_beat) begin
                        state_next = DONE;
                    end else begin
                        state_next = gap_zero ? VALID : WAIT;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        valid_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state)
            WAIT:    busy_o = 1'b1;
            VALID: begin
                busy_o  = 1'b1;
                valid_o = 1'b1;
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beats_sent_o <= '0;
            data_o       <= '0;
            cnt          <= '0;
        end else if (start_go) begin
            beats_sent_o <= '0;
            data_o       <= data_first;
            cnt          <= gap_val;
        end else if (state == WAIT) begin
            cnt <= cnt - CntW'(1);
        end else if (hs) begin
            beats_sent_o <= beats_sent_o + BeatW'(1);
            data_o       <= data_step;
            cnt          <= gap_val;
        end
    end

endmodule
